hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush. It handles load-use stalls, taken-branch flushes and data-memory wait states, and produces EX-stage forwarding selects for the ALU operand muxes.

---
 rtl/hazard_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage MIPS hazard controller: load-use stalls, branch flushes,
//            data-memory wait states and EX-stage forwarding selects.
//            Optional macro HAZARD_PERF_CNT_EN adds saturating perf counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
   parameter int REG_ADDR_W      = 5,
   parameter int LU_STALL_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
   ,parameter int CNT_W          = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] ifid_rs,
   input  logic [REG_ADDR_W-1:0] ifid_rt,
   input  logic                  ifid_uses_rt,
   input  logic [REG_ADDR_W-1:0] idex_rs,
   input  logic [REG_ADDR_W-1:0] idex_rt,
   input  logic                  idex_memread,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic                  exmem_regwrite,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic                  memwb_regwrite,
   input  logic                  ex_branch_taken,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  freeze_back,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0]     perf_lu_stalls
   ,output logic [CNT_W-1:0]     perf_flushes
   ,output logic [CNT_W-1:0]     perf_mem_waits
`endif
);

   localparam logic [1:0] S_RUN      = 2'd0;
   localparam logic [1:0] S_LU_STALL = 2'd1;
   localparam logic [1:0] S_MEM_WAIT = 2'd2;

   localparam logic [2:0] A_NORMAL   = 3'd0;
   localparam logic [2:0] A_FREEZE   = 3'd1;
   localparam logic [2:0] A_FLUSH    = 3'd2;
   localparam logic [2:0] A_LU_START = 3'd3;
   localparam logic [2:0] A_LU_CONT  = 3'd4;

   localparam logic [2:0] LU_LOAD = 3'(LU_STALL_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       flush_pending_q, flush_pending_d;
   logic [2:0] action;
   logic       lu, mem_stall;
   logic [1:0] fwd_a_raw, fwd_b_raw;

   assign lu = idex_memread && (idex_rt != '0) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
   assign mem_stall = dmem_req && !dmem_ready;

   always_comb begin
      fwd_a_raw = 2'b00;
      fwd_b_raw = 2'b00;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_rs))
         fwd_a_raw = 2'b10;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_rs))
         fwd_a_raw = 2'b01;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_rt))
         fwd_b_raw = 2'b10;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_rt))
         fwd_b_raw = 2'b01;
   end

   // The ready cycle of a wait re-enters whichever decision was held off:
   // an owed load-use bubble, a latched branch flush, or a fresh RUN check.
   always_comb begin
      action = A_NORMAL;
      case (state_q)
         S_RUN: begin
            if (mem_stall)            action = A_FREEZE;
            else if (ex_branch_taken) action = A_FLUSH;
            else if (lu)              action = A_LU_START;
            else                      action = A_NORMAL;
         end
         S_LU_STALL: begin
            if (mem_stall) action = A_FREEZE;
            else           action = A_LU_CONT;
         end
         S_MEM_WAIT: begin
            if (!dmem_ready)          action = A_FREEZE;
            else if (cnt_q != 3'd0)   action = A_LU_CONT;
            else if (flush_pending_q) action = A_FLUSH;
            else if (lu)              action = A_LU_START;
            else                      action = A_NORMAL;
         end
         default: action = A_NORMAL;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      flush_pending_d = flush_pending_q;
      case (action)
         A_FREEZE: begin
            state_d = S_MEM_WAIT;
            if ((state_q == S_RUN) && ex_branch_taken)
               flush_pending_d = 1'b1;
         end
         A_FLUSH: begin
            state_d         = S_RUN;
            flush_pending_d = 1'b0;
         end
         A_LU_START: begin
            cnt_d   = LU_LOAD;
            state_d = (LU_LOAD != 3'd0) ? S_LU_STALL : S_RUN;
         end
         A_LU_CONT: begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd1) ? S_RUN : S_LU_STALL;
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_RUN;
         cnt_q           <= 3'd0;
         flush_pending_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      freeze_back = 1'b0;
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;
      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         fwd_a       = 2'b00;
         fwd_b       = 2'b00;
      end else begin
         case (action)
            A_FREEZE: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               freeze_back = 1'b1;
            end
            A_FLUSH: begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end
            A_LU_START, A_LU_CONT: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] perf_lu_q, perf_lu_d;
   logic [CNT_W-1:0] perf_fl_q, perf_fl_d;
   logic [CNT_W-1:0] perf_mw_q, perf_mw_d;

   always_comb begin
      perf_lu_d = perf_lu_q;
      perf_fl_d = perf_fl_q;
      perf_mw_d = perf_mw_q;
      if (((action == A_LU_START) || (action == A_LU_CONT)) && (perf_lu_q != '1))
         perf_lu_d = perf_lu_q + CNT_W'(1);
      if ((action == A_FLUSH) && (perf_fl_q != '1))
         perf_fl_d = perf_fl_q + CNT_W'(1);
      if ((state_q == S_MEM_WAIT) && (perf_mw_q != '1))
         perf_mw_d = perf_mw_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lu_q <= '0;
         perf_fl_q <= '0;
         perf_mw_q <= '0;
      end else begin
         perf_lu_q <= perf_lu_d;
         perf_fl_q <= perf_fl_d;
         perf_mw_q <= perf_mw_d;
      end
   end

   assign perf_lu_stalls = perf_lu_q;
   assign perf_flushes   = perf_fl_q;
   assign perf_mem_waits = perf_mw_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed + random bench for hazard_ctrl, two instances
//            (LU_STALL_CYCLES = 1 and 3) against a bubble-debt reference model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
   logic       ifid_uses_rt, idex_memread, exmem_regwrite, memwb_regwrite;
   logic       ex_branch_taken, dmem_req, dmem_ready;

   logic       pc_write_1, ifid_write_1, ifid_flush_1, idex_bubble_1, freeze_back_1;
   logic [1:0] fwd_a_1, fwd_b_1;
   logic       pc_write_3, ifid_write_3, ifid_flush_3, idex_bubble_3, freeze_back_3;
   logic [1:0] fwd_a_3, fwd_b_3;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] p_lu_1, p_fl_1, p_mw_1, p_lu_3, p_fl_3, p_mw_3;
`endif

   hazard_ctrl #(.REG_ADDR_W(5), .LU_STALL_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread),
      .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
      .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
      .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write_1), .ifid_write(ifid_write_1), .ifid_flush(ifid_flush_1),
      .idex_bubble(idex_bubble_1), .freeze_back(freeze_back_1),
      .fwd_a(fwd_a_1), .fwd_b(fwd_b_1)
`ifdef HAZARD_PERF_CNT_EN
      ,.perf_lu_stalls(p_lu_1), .perf_flushes(p_fl_1), .perf_mem_waits(p_mw_1)
`endif
   );

   hazard_ctrl #(.REG_ADDR_W(5), .LU_STALL_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_memread(idex_memread),
      .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
      .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
      .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_write(pc_write_3), .ifid_write(ifid_write_3), .ifid_flush(ifid_flush_3),
      .idex_bubble(idex_bubble_3), .freeze_back(freeze_back_3),
      .fwd_a(fwd_a_3), .fwd_b(fwd_b_3)
`ifdef HAZARD_PERF_CNT_EN
      ,.perf_lu_stalls(p_lu_3), .perf_flushes(p_fl_3), .perf_mem_waits(p_mw_3)
`endif
   );

   int total = 0;
   int bad   = 0;
   int bub3  = 0;

   // Reference model per instance: bubbles still owed, waiting on memory,
   // and a branch flush deferred until memory completes.
   int lus[2]     = '{1, 3};
   int left[2]    = '{0, 0};
   bit waiting[2] = '{1'b0, 1'b0};
   bit pend[2]    = '{1'b0, 1'b0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] src);
      if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == src) return 2'b10;
      if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   // Compare both instances at the falling edge, then advance the model.
   task automatic cyc(input string tag);
      logic [8:0] want, got;
      logic [3:0] fw;
      logic       lu, ms;
      @(negedge clk);
      lu = idex_memread && idex_rt != 5'd0 &&
           (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
      ms = dmem_req && !dmem_ready;
      fw = {fwd_ref(idex_rs), fwd_ref(idex_rt)};
      if (idex_bubble_3) bub3++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            want = {5'b00110, 4'b0000};
            left[k] = 0; waiting[k] = 1'b0; pend[k] = 1'b0;
         end else if (waiting[k] && !dmem_ready) begin
            want = {5'b00001, fw};
         end else if (ms) begin
            want = {5'b00001, fw};
            if (left[k] == 0 && ex_branch_taken) pend[k] = 1'b1;
            waiting[k] = 1'b1;
         end else if (left[k] > 0) begin
            want = {5'b00010, fw};
            left[k]--; waiting[k] = 1'b0;
         end else if (waiting[k] ? pend[k] : ex_branch_taken) begin
            want = {5'b11110, fw};
            pend[k] = 1'b0; waiting[k] = 1'b0;
         end else if (lu) begin
            want = {5'b00010, fw};
            left[k] = lus[k] - 1; waiting[k] = 1'b0;
         end else begin
            want = {5'b11000, fw};
            waiting[k] = 1'b0;
         end
         if (k == 0)
            got = {pc_write_1, ifid_write_1, ifid_flush_1, idex_bubble_1, freeze_back_1, fwd_a_1, fwd_b_1};
         else
            got = {pc_write_3, ifid_write_3, ifid_flush_3, idex_bubble_3, freeze_back_3, fwd_a_3, fwd_b_3};
         check($sformatf("%s/lu%0d", tag, lus[k]), 32'(got), 32'(want));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0;
      ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
      idex_rs = 5'd0; idex_rt = 5'd0; idex_memread = 1'b0;
      exmem_rd = 5'd0; exmem_regwrite = 1'b0;
      memwb_rd = 5'd0; memwb_regwrite = 1'b0;
      ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      exmem_rd = 5'd3; exmem_regwrite = 1'b1; idex_rs = 5'd3;
      cyc("reset");
      cyc("reset_hold");
      idle();
      cyc("idle");

      // load-use on rs
      idex_memread = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2;
      #1;
      check("lu_pc_write", pc_write_1, 1'b0);
      check("lu_bubble", idex_bubble_1, 1'b1);
      cyc("lu");
      idle();
      #1;
      check("lu_resume_pc", pc_write_1, 1'b1);
      cyc("lu_after");
      cyc("lu_drain");
      cyc("lu_drain2");

      // forwarding priority and $0
      exmem_rd = 5'd3; memwb_rd = 5'd3; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
      idex_rs = 5'd3; idex_rt = 5'd3;
      #1;
      check("fwd_a_exmem", fwd_a_1, 2'b10);
      cyc("fwd_exmem");
      exmem_regwrite = 1'b0;
      #1;
      check("fwd_a_memwb", fwd_a_1, 2'b01);
      check("fwd_b_memwb", fwd_b_3, 2'b01);
      cyc("fwd_memwb");
      exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
      #1;
      check("fwd_a_zero", fwd_a_1, 2'b00);
      cyc("fwd_zero");

      // taken branch with coincident load-use
      idle();
      ex_branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2;
      #1;
      check("br_flush", ifid_flush_3, 1'b1);
      check("br_pc_write", pc_write_3, 1'b1);
      cyc("br_lu");
      idle();
      #1;
      check("br_no_stall", pc_write_3, 1'b1);
      check("br_one_flush", ifid_flush_1, 1'b0);
      cyc("br_after");

      // memory wait with branch on the first cycle
      dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
      cyc("mw1");
      ex_branch_taken = 1'b0;
      cyc("mw2");
      cyc("mw3");
      dmem_ready = 1'b1;
      #1;
      check("mw_ready_flush", ifid_flush_1, 1'b1);
      check("mw_ready_pc", pc_write_1, 1'b1);
      check("mw_ready_freeze", freeze_back_1, 1'b0);
      cyc("mw_ready");
      idle();
      cyc("mw_after");

      // three-bubble stall interrupted by a memory wait
      bub3 = 0;
      idex_memread = 1'b1; idex_rt = 5'd5; ifid_uses_rt = 1'b1; ifid_rt = 5'd5; ifid_rs = 5'd1;
      cyc("lu3_1");
      idle();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      cyc("lu3_ms");
      cyc("lu3_wait");
      dmem_ready = 1'b1;
      cyc("lu3_ready");
      idle();
      for (int i = 0; i < 4; i++) cyc("lu3_tail");
      check("lu3_bubbles", bub3, 3);

      // reset in the middle of a load-use stall
      idex_memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
      cyc("lu3_again");
      idle();
      rst = 1'b1;
      cyc("rst_mid");
      rst = 1'b0;
      #1;
      check("post_rst_pc", pc_write_3, 1'b1);
      check("post_rst_ifid", ifid_write_3, 1'b1);
      cyc("post_rst");

      for (int i = 0; i < 3000; i++) begin
         rst             = ($urandom_range(0, 99) == 0);
         ifid_rs         = 5'($urandom_range(0, 3));
         ifid_rt         = 5'($urandom_range(0, 3));
         ifid_uses_rt    = 1'($urandom_range(0, 1));
         idex_rs         = 5'($urandom_range(0, 3));
         idex_rt         = 5'($urandom_range(0, 3));
         idex_memread    = ($urandom_range(0, 2) == 0);
         exmem_rd        = 5'($urandom_range(0, 3));
         exmem_regwrite  = 1'($urandom_range(0, 1));
         memwb_rd        = 5'($urandom_range(0, 3));
         memwb_regwrite  = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         dmem_req        = ($urandom_range(0, 2) == 0);
         dmem_ready      = 1'($urandom_range(0, 1));
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
